// File: rtl/mig7_app_model.sv
// Behavioural model of the MIG-7 user (app_*) interface: command/write-data FIFOs, backing memory and read pipeline.
// Optional MIG7_APP_MODEL_THROTTLE_EN: a free-running 2-bit counter drops app_rdy/app_wdf_rdy one cycle in four.
module mig7_app_model #(
    parameter int DEPTH_LOG2   = 8,
    parameter int CALIB_CYCLES = 16,
    parameter int RD_LATENCY   = 4
) (
    input  logic         rst,
    input  logic         clk,
    input  logic [27:0]  app_addr,
    input  logic [2:0]   app_cmd,
    input  logic         app_en,
    input  logic [127:0] app_wdf_data,
    input  logic         app_wdf_end,
    input  logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_wren,
    output logic [127:0] app_rd_data,
    output logic         app_rd_data_end,
    output logic         app_rd_data_valid,
    output logic         app_rdy,
    output logic         app_wdf_rdy,
    input  logic         app_sr_req,
    input  logic         app_ref_req,
    input  logic         app_zq_req,
    output logic         app_sr_active,
    output logic         app_ref_ack,
    output logic         app_zq_ack,
    output logic         init_calib_complete
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CALIB_CYCLES + 1) + 1;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    // Every command is a single beat, so app_wdf_end carries no information here.
    logic unused_inputs;
    assign unused_inputs = ^{app_wdf_end, app_addr};

    // Calibration
    logic [CW-1:0] calib_cnt_reg;
    logic          calib_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            calib_cnt_reg  <= '0;
            calib_done_reg <= 1'b0;
        end else if (!calib_done_reg) begin
            calib_cnt_reg <= calib_cnt_reg + 1'b1;
            if (calib_cnt_reg + 1'b1 == CW'(CALIB_CYCLES))
                calib_done_reg <= 1'b1;
        end
    end

    assign init_calib_complete = calib_done_reg;

    logic thr_block;
`ifdef MIG7_APP_MODEL_THROTTLE_EN
    logic [1:0] thr_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) thr_cnt_reg <= 2'd0;
        else     thr_cnt_reg <= thr_cnt_reg + 2'd1;
    end

    assign thr_block = (thr_cnt_reg == 2'd3);
`else
    assign thr_block = 1'b0;
`endif

    // Command FIFO {cmd, word index, is_write} and write-data FIFO {data, mask}
    logic [2:0]            cq_cmd_reg [4];
    logic [DEPTH_LOG2-1:0] cq_idx_reg [4];
    logic                  cq_wr_reg  [4];
    logic [1:0]            cq_wr_ptr_reg, cq_rd_ptr_reg;
    logic [2:0]            cq_count_reg;

    logic [127:0]          wdf_data_reg [4];
    logic [15:0]           wdf_mask_reg [4];
    logic [1:0]            wdf_wr_ptr_reg, wdf_rd_ptr_reg;
    logic [2:0]            wdf_count_reg;

    // Ready comes from the registered counts, so a full FIFO never pushes in its pop cycle.
    assign app_rdy     = calib_done_reg & (cq_count_reg  != 3'd4) & ~thr_block;
    assign app_wdf_rdy = calib_done_reg & (wdf_count_reg != 3'd4) & ~thr_block;

    logic cq_push, wdf_push;
    assign cq_push  = app_en & app_rdy;
    assign wdf_push = app_wdf_wren & app_wdf_rdy;

    logic [2:0]            head_cmd;
    logic [DEPTH_LOG2-1:0] head_idx;
    logic                  head_wr;
    logic [127:0]          head_data;
    logic [15:0]           head_mask;

    assign head_cmd  = cq_cmd_reg[cq_rd_ptr_reg];
    assign head_idx  = cq_idx_reg[cq_rd_ptr_reg];
    assign head_wr   = cq_wr_reg[cq_rd_ptr_reg];
    assign head_data = wdf_data_reg[wdf_rd_ptr_reg];
    assign head_mask = wdf_mask_reg[wdf_rd_ptr_reg];

    logic cq_pop, wdf_pop, wr_exec, rd_exec;

    always_comb begin
        cq_pop  = 1'b0;
        wdf_pop = 1'b0;
        wr_exec = 1'b0;
        rd_exec = 1'b0;
        if (cq_count_reg != 3'd0) begin
            if (head_wr) begin
                // A write without its data blocks everything queued behind it.
                if (wdf_count_reg != 3'd0) begin
                    wr_exec = 1'b1;
                    cq_pop  = 1'b1;
                    wdf_pop = 1'b1;
                end
            end else if (head_cmd == CMD_READ) begin
                rd_exec = 1'b1;
                cq_pop  = 1'b1;
            end else begin
                cq_pop  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cq_wr_ptr_reg  <= 2'd0;
            cq_rd_ptr_reg  <= 2'd0;
            cq_count_reg   <= 3'd0;
            wdf_wr_ptr_reg <= 2'd0;
            wdf_rd_ptr_reg <= 2'd0;
            wdf_count_reg  <= 3'd0;
        end else begin
            if (cq_push)  cq_wr_ptr_reg  <= cq_wr_ptr_reg + 2'd1;
            if (cq_pop)   cq_rd_ptr_reg  <= cq_rd_ptr_reg + 2'd1;
            if (wdf_push) wdf_wr_ptr_reg <= wdf_wr_ptr_reg + 2'd1;
            if (wdf_pop)  wdf_rd_ptr_reg <= wdf_rd_ptr_reg + 2'd1;
            cq_count_reg  <= cq_count_reg  + {2'b00, cq_push}  - {2'b00, cq_pop};
            wdf_count_reg <= wdf_count_reg + {2'b00, wdf_push} - {2'b00, wdf_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (cq_push) begin
            cq_cmd_reg[cq_wr_ptr_reg] <= app_cmd;
            cq_idx_reg[cq_wr_ptr_reg] <= app_addr[3 +: DEPTH_LOG2];
            cq_wr_reg[cq_wr_ptr_reg]  <= (app_cmd == CMD_WRITE);
        end
        if (wdf_push) begin
            wdf_data_reg[wdf_wr_ptr_reg] <= app_wdf_data;
            wdf_mask_reg[wdf_wr_ptr_reg] <= app_wdf_mask;
        end
    end

    logic [15:0] byte_we;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte_we
            assign byte_we[gi] = wr_exec & ~rst & ~head_mask[gi];
        end
    endgenerate

    // Memory is zero at power-up and deliberately untouched by reset.
    logic [127:0] mem [WORDS] = '{default: '0};
    logic [127:0] rd_data_pipe_reg [RD_LATENCY];
    logic [RD_LATENCY-1:0] rd_vld_pipe_reg;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 16; b++) begin
            if (byte_we[b])
                mem[head_idx][b*8 +: 8] <= head_data[b*8 +: 8];
        end
        rd_data_pipe_reg[0] <= mem[head_idx];
        for (int i = 1; i < RD_LATENCY; i++)
            rd_data_pipe_reg[i] <= rd_data_pipe_reg[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_pipe_reg <= '0;
        end else begin
            rd_vld_pipe_reg[0] <= rd_exec;
            for (int i = 1; i < RD_LATENCY; i++)
                rd_vld_pipe_reg[i] <= rd_vld_pipe_reg[i-1];
        end
    end

    assign app_rd_data_valid = rd_vld_pipe_reg[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld_pipe_reg[RD_LATENCY-1];
    assign app_rd_data       = rd_vld_pipe_reg[RD_LATENCY-1] ? rd_data_pipe_reg[RD_LATENCY-1] : '0;

    // Maintenance handshakes
    logic ref_req_d1_reg, ref_ack_reg, zq_req_d1_reg, zq_ack_reg, sr_active_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_req_d1_reg <= 1'b0;
            ref_ack_reg    <= 1'b0;
            zq_req_d1_reg  <= 1'b0;
            zq_ack_reg     <= 1'b0;
            sr_active_reg  <= 1'b0;
        end else begin
            ref_req_d1_reg <= app_ref_req;
            ref_ack_reg    <= ref_req_d1_reg;
            zq_req_d1_reg  <= app_zq_req;
            zq_ack_reg     <= zq_req_d1_reg;
            sr_active_reg  <= app_sr_req;
        end
    end

    assign app_ref_ack   = ref_ack_reg;
    assign app_zq_ack    = zq_ack_reg;
    assign app_sr_active = sr_active_reg;

endmodule

// File: tb/tb_mig7_app_model.sv
// Self-checking bench for mig7_app_model: vector table of writes/reads plus directed stall, fill, maintenance and reset sequences.
module tb_mig7_app_model;

    localparam int L     = 4;
    localparam int CALIB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic [127:0] app_wdf_data;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic [127:0] app_rd_data;
    logic         app_rd_data_end;
    logic         app_rd_data_valid;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic         app_sr_req, app_ref_req, app_zq_req;
    logic         app_sr_active, app_ref_ack, app_zq_ack;
    logic         init_calib_complete;

    mig7_app_model #(.DEPTH_LOG2(8), .CALIB_CYCLES(CALIB), .RD_LATENCY(L)) dut (
        .rst(rst), .clk(clk), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
        .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
        .app_sr_active(app_sr_active), .app_ref_ack(app_ref_ack), .app_zq_ack(app_zq_ack),
        .init_calib_complete(init_calib_complete)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each read pushes {data, edge count at which valid must be visible}
    typedef struct {
        logic [127:0] data;
        int           at;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got data=%0h at cycle %0d expected no valid", app_rd_data, cyc);
            end else begin
                sb_e = sb_q.pop_front();
                if (app_rd_data !== sb_e.data || cyc != sb_e.at || app_rd_data_end !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_data got=%0h cycle=%0d end=%0b expected=%0h cycle=%0d end=1",
                             app_rd_data, cyc, app_rd_data_end, sb_e.data, sb_e.at);
                end
            end
        end else begin
            checks++;
            if (app_rd_data !== 128'h0 || app_rd_data_end !== 1'b0) begin
                errors++;
                $display("FAIL rd_idle got data=%0h end=%0b expected 0", app_rd_data, app_rd_data_end);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Both issue tasks start just after a rising edge and return just after the accepting edge.
    task automatic cmd_issue(input logic [2:0] c, input logic [27:0] a, output int acc);
        app_en = 1'b1; app_cmd = c; app_addr = a; acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (app_rdy) begin
                @(posedge clk); #1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        app_en = 1'b0;
        if (acc < 0) chk("cmd_accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic data_issue(input logic [127:0] d, input logic [15:0] m, output int acc);
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m; acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (app_wdf_rdy) begin
                @(posedge clk); #1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        if (acc < 0) chk("data_accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic read_expect(input logic [27:0] a, input logic [127:0] exp);
        int acc;
        exp_t e;
        cmd_issue(3'b001, a, acc);
        e.data = exp;
        e.at   = acc + L;
        sb_q.push_back(e);
    endtask

    typedef struct {
        logic         is_rd;
        logic         data_first;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  mask;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] D0 = 128'hcafebabe_12345678_AA55AA55_55AA55AA;
    localparam logic [127:0] DX = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    vec_t tbl[11];

    initial begin
        int acc, acc2, k, j;
        logic adv_c, adv_d;
        exp_t e;

        rst = 1'b1; app_addr = '0; app_cmd = '0; app_en = 1'b0; app_wdf_data = '0;
        app_wdf_end = 1'b0; app_wdf_mask = '0; app_wdf_wren = 1'b0;
        app_sr_req = 1'b0; app_ref_req = 1'b0; app_zq_req = 1'b0;

        tbl[0]  = '{1'b0, 1'b0, 28'h0000000, D0, 16'h0000, 128'h0};
        tbl[1]  = '{1'b1, 1'b0, 28'h0000000, 128'h0, 16'h0, D0};
        tbl[2]  = '{1'b0, 1'b0, 28'h0000010, {128{1'b1}}, 16'h0000, 128'h0};
        tbl[3]  = '{1'b0, 1'b0, 28'h0000010, 128'h0, 16'h00FF, 128'h0};
        tbl[4]  = '{1'b1, 1'b0, 28'h0000010, 128'h0, 16'h0, {64'h0, 64'hFFFFFFFF_FFFFFFFF}};
        tbl[5]  = '{1'b1, 1'b0, 28'h0000800, 128'h0, 16'h0, D0};
        tbl[6]  = '{1'b0, 1'b0, 28'h0000018, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hF0F0, 128'h0};
        tbl[7]  = '{1'b1, 1'b0, 28'h0000018, 128'h0, 16'h0, 128'h00000000_44556677_00000000_CCDDEEFF};
        tbl[8]  = '{1'b1, 1'b0, 28'h0000020, 128'h0, 16'h0, 128'h0};
        tbl[9]  = '{1'b0, 1'b1, 28'h1000000, DX, 16'h0000, 128'h0};
        tbl[10] = '{1'b1, 1'b0, 28'h0000000, 128'h0, 16'h0, DX};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            128'({app_rdy, app_wdf_rdy, app_rd_data_valid, init_calib_complete, app_ref_ack, app_zq_ack, app_sr_active}),
            128'(0));

        sync();
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("calib_c%0d", c), 128'(init_calib_complete), 128'(c >= CALIB));
            chk($sformatf("rdy_c%0d", c), 128'({app_rdy, app_wdf_rdy}), (c >= CALIB) ? 128'(3) : 128'(0));
        end

        sync();
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_rd) begin
                read_expect(tbl[i].addr, tbl[i].exp);
            end else if (tbl[i].data_first) begin
                data_issue(tbl[i].wdata, tbl[i].mask, acc);
                cmd_issue(3'b000, tbl[i].addr, acc);
            end else begin
                cmd_issue(3'b000, tbl[i].addr, acc);
                data_issue(tbl[i].wdata, tbl[i].mask, acc);
            end
        end
        repeat (L + 4) sync();

        // Write stalled on late data; the read queued behind it must wait for it.
        cmd_issue(3'b000, 28'h0000008, acc);
        cmd_issue(3'b001, 28'h0000008, acc2);
        sync();
        sync();
        data_issue(128'hDEADBEEF_0BADF00D_13572468_FEDCBA98, 16'h0, acc);
        e.data = 128'hDEADBEEF_0BADF00D_13572468_FEDCBA98;
        e.at   = acc + 1 + L;
        sb_q.push_back(e);
        repeat (L + 4) sync();

        // Fill the command queue with data-less writes, then feed the data.
        k = 0; j = 0;
        app_en = 1'b1; app_cmd = 3'b000;
        for (int i = 0; i < 20 && k < 4; i++) begin
            app_addr = 28'h40 + 28'(k * 8);
            @(negedge clk); adv_c = app_rdy;
            @(posedge clk); #1;
            if (adv_c) k++;
        end
        app_addr = 28'h40 + 28'(k * 8);
        chk("fill_accepted", 128'(k), 128'(4));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fill_rdy_low%0d", i), 128'(app_rdy), 128'(0));
            @(posedge clk); #1;
        end
        for (int i = 0; i < 60 && (k < 5 || j < 5); i++) begin
            app_en = (k < 5);
            app_addr = 28'h40 + 28'(k * 8);
            app_wdf_wren = (j < 5);
            app_wdf_end  = (j < 5);
            app_wdf_mask = 16'h0;
            app_wdf_data = {4{32'(j + 1) * 32'h01010101}};
            @(negedge clk);
            adv_c = app_en & app_rdy;
            adv_d = app_wdf_wren & app_wdf_rdy;
            @(posedge clk); #1;
            if (adv_c) k++;
            if (adv_d) j++;
        end
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        chk("drain_counts", 128'({8'(k), 8'(j)}), 128'({8'd5, 8'd5}));
        repeat (6) sync();
        @(negedge clk);
        chk("drain_rdy", 128'(app_rdy), 128'(1));
        sync();
        for (int i = 0; i < 5; i++)
            read_expect(28'h40 + 28'(i * 8), {4{32'(i + 1) * 32'h01010101}});
        repeat (L + 4) sync();

        // Maintenance handshakes
        app_ref_req = 1'b1; app_zq_req = 1'b1; app_sr_req = 1'b1;
        sync();
        app_ref_req = 1'b0; app_zq_req = 1'b0;
        @(negedge clk);
        chk("maint_d1", 128'({app_ref_ack, app_zq_ack, app_sr_active}), 128'(3'b001));
        @(negedge clk);
        chk("maint_d2", 128'({app_ref_ack, app_zq_ack, app_sr_active}), 128'(3'b111));
        app_sr_req = 1'b0;
        @(negedge clk);
        chk("maint_d3", 128'({app_ref_ack, app_zq_ack, app_sr_active}), 128'(3'b000));
        sync();

        // Reset while a read is in flight: nothing may come out.
        cmd_issue(3'b001, 28'h0000800, acc);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_calib_cleared", 128'({init_calib_complete, app_rdy}), 128'(0));
        for (int i = 0; i < 3 * L; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_valid%0d", i), 128'(app_rd_data_valid), 128'(0));
        end
        repeat (CALIB + 4) sync();
        read_expect(28'h0000000, DX);
        repeat (L + 4) sync();

        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got cycle=%0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
